// File: rtl/hilo_mult_sequencer_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply unit.
//   - op encodings for the Op field
//   - FSM state type
//   - default operand width
package hilo_pkg;
   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_MADD  = 3'b010;
   localparam logic [2:0] OP_MSUB  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

   // All four multiply flavours live in the lower half of the encoding space.
   function automatic logic is_mul(input logic [2:0] op);
      return ~op[2];
   endfunction
endpackage

// File: rtl/hilo_mult_sequencer_if.sv
// hilo_mult_sequencer_if: decode-side bus of the HI/LO unit.
//   master (decode) drives Start/Op/A/B/Flush; reads Busy/Done/Hi/Lo.
//   slave  (unit)   is the reverse.
interface hilo_mult_sequencer_if import hilo_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Flush;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;

   modport master (output Start, Op, A, B, Flush, input Busy, Done, Hi, Lo);
   modport slave  (input Start, Op, A, B, Flush, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/hilo_mult_sequencer_mul_iter_datapath.sv
// mul_iter_datapath: unsigned 1-bit-per-cycle shift-add multiplier.
//   Clk, Rst_n      clock, async active-low reset
//   load            capture operands, clear product and counter
//   step            one iteration (conditional add, shift, count)
//   clear           abandon work; zero all state (highest priority)
//   mcand_in        multiplicand magnitude
//   mplier_in       multiplier magnitude
//   last            counter is on the final iteration
//   product         2*WIDTH accumulated product
module mul_iter_datapath import hilo_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               load,
   input  logic               step,
   input  logic               clear,
   input  logic [WIDTH-1:0]   mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_q, prod_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (clear) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (load) begin
         mcand_q  <= {{WIDTH{1'b0}}, mcand_in};
         mplier_q <= mplier_in;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (step) begin
         if (mplier_q[0]) prod_q <= prod_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + 1'b1;
      end
   end

   assign last    = (cnt_q == CW'(WIDTH - 1));
   assign product = prod_q;
endmodule

// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: multi-cycle HI/LO unit (MULT/MULTU/MADD/MSUB, MTHI/MTLO).
//   Clk, Rst_n   clock, async active-low reset
//   bus (slave)  Start/Op/A/B/Flush in; Busy/Done/Hi/Lo out
// The multiplier works on magnitudes; the sign is re-applied in FIX, where
// the result is written or accumulated into {Hi,Lo}.
module hilo_mult_sequencer import hilo_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   hilo_mult_sequencer_if.slave bus
);
   state_t             state_q, state_d;
   logic [2:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               busy_q, done_q;

   logic               sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               load, step, clear, last;
   logic               fix_wr, wr_hi, wr_lo, done_d;
   logic [2*WIDTH-1:0] product, p, acc, res;

   // Two's-complement negate of the most negative value yields 2^(W-1),
   // which is exactly right when read as unsigned.
   assign sgn   = (bus.Op != OP_MULTU);
   assign a_mag = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
   assign b_mag = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;

   mul_iter_datapath #(.WIDTH(WIDTH)) u_dp (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .load      (load),
      .step      (step),
      .clear     (clear),
      .mcand_in  (a_mag),
      .mplier_in (b_mag),
      .last      (last),
      .product   (product)
   );

   assign p   = neg_q ? -product : product;
   assign acc = {hi_q, lo_q};

   always_comb begin
      res = p;
      case (op_q)
         OP_MADD: res = acc + p;
         OP_MSUB: res = acc - p;
         default: res = p;
      endcase
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      clear   = 1'b0;
      fix_wr  = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // Flush beats a same-cycle Start; reserved ops fall through.
            if (bus.Start && !bus.Flush) begin
               if (is_mul(bus.Op)) begin
                  load    = 1'b1;
                  state_d = ITER;
               end else if (bus.Op == OP_MTHI) begin
                  wr_hi  = 1'b1;
                  done_d = 1'b1;
               end else if (bus.Op == OP_MTLO) begin
                  wr_lo  = 1'b1;
                  done_d = 1'b1;
               end
            end
         end
         ITER: begin
            if (bus.Flush) begin
               clear   = 1'b1;
               state_d = IDLE;
            end else begin
               step = 1'b1;
               if (last) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (bus.Flush) begin
               clear = 1'b1;
            end else begin
               fix_wr = 1'b1;
               done_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_MULT;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         if (load) begin
            op_q  <= bus.Op;
            neg_q <= sgn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
         end
         if (fix_wr) begin
            hi_q <= res[2*WIDTH-1:WIDTH];
            lo_q <= res[WIDTH-1:0];
         end
         if (wr_hi) hi_q <= bus.A;
         if (wr_lo) lo_q <= bus.A;
      end
   end

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.Hi   = hi_q;
   assign bus.Lo   = lo_q;
endmodule

// File: tb/tb_hilo_mult_sequencer.sv
module tb_hilo_mult_sequencer;
   import hilo_pkg::*;

   localparam int W = 32;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   hilo_mult_sequencer_if #(.WIDTH(W)) bus ();
   hilo_mult_sequencer #(.WIDTH(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [31:0] hi, lo;
      int          lat;
      int          busy;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op; return cycles from the sampling edge until Done is seen
   // and how many of those cycles had Busy high.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      lat = 0; bcnt = 0;
      while (bus.Done !== 1'b1 && lat < 60) begin
         if (bus.Busy === 1'b1) bcnt++;
         @(posedge Clk); #1;
         lat++;
      end
      if (lat >= 60) begin
         tests++; fails++;
         $display("FAIL done_timeout: op %b got no Done within 60 cycles", op);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bc, nd, nb;

      vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 33};
      vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33};
      vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 33};
      vecs[3] = '{OP_MTHI,  32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 0,  0};
      vecs[4] = '{OP_MTLO,  32'h00000010, 32'h0,        32'h00000000, 32'h00000010, 0,  0};
      vecs[5] = '{OP_MADD,  32'h00000002, 32'h00000003, 32'h00000000, 32'h00000016, 33, 33};
      vecs[6] = '{OP_MSUB,  32'h00000005, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33};
      vecs[7] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, 33};
      vecs[8] = '{OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEC, 33, 33};

      bus.Start = 1'b0; bus.Flush = 1'b0; bus.Op = 3'b000; bus.A = '0; bus.B = '0;

      #23;
      chk("rst_hi",   {32'h0, bus.Hi}, 64'h0);
      chk("rst_lo",   {32'h0, bus.Lo}, 64'h0);
      chk("rst_busy", {63'h0, bus.Busy}, 64'h0);
      chk("rst_done", {63'h0, bus.Done}, 64'h0);
      @(negedge Clk); Rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
         chk($sformatf("v%0d_lat", i),  64'(lat), 64'(vecs[i].lat));
         chk($sformatf("v%0d_busy", i), 64'(bc),  64'(vecs[i].busy));
         chk($sformatf("v%0d_hi", i),   {32'h0, bus.Hi}, {32'h0, vecs[i].hi});
         chk($sformatf("v%0d_lo", i),   {32'h0, bus.Lo}, {32'h0, vecs[i].lo});
         @(posedge Clk); #1;
         chk($sformatf("v%0d_done_drop", i), {63'h0, bus.Done}, 64'h0);
      end

      // Start during ITER is ignored, not queued.
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MULTU; bus.A = 32'd4; bus.B = 32'd5;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      nd = 0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge Clk);
         if (c == 3) begin bus.Start = 1'b1; bus.Op = OP_MTLO; bus.A = 32'h99; end
         else bus.Start = 1'b0;
         @(posedge Clk); #1;
         if (bus.Done) nd++;
      end
      bus.Start = 1'b0;
      chk("ign_ndone", 64'(nd), 64'd1);
      chk("ign_lo", {32'h0, bus.Lo}, 64'h14);
      chk("ign_hi", {32'h0, bus.Hi}, 64'h0);

      // Flush mid-ITER leaves Hi/Lo alone and suppresses Done.
      run_op(OP_MTHI, 32'h1, 32'h0, lat, bc);
      run_op(OP_MTLO, 32'h2, 32'h0, lat, bc);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MULT; bus.A = 32'd9; bus.B = 32'd9;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      repeat (9) @(posedge Clk);
      @(negedge Clk); bus.Flush = 1'b1;
      @(posedge Clk); #1; bus.Flush = 1'b0;
      chk("flush_busy", {63'h0, bus.Busy}, 64'h0);
      chk("flush_done", {63'h0, bus.Done}, 64'h0);
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge Clk); #1;
         if (bus.Done) nd++;
      end
      chk("flush_nodone", 64'(nd), 64'd0);
      chk("flush_hi", {32'h0, bus.Hi}, 64'h1);
      chk("flush_lo", {32'h0, bus.Lo}, 64'h2);

      // Flush in IDLE drops a same-cycle Start.
      @(negedge Clk);
      bus.Start = 1'b1; bus.Flush = 1'b1; bus.Op = OP_MTLO; bus.A = 32'h77;
      @(posedge Clk); #1;
      bus.Start = 1'b0; bus.Flush = 1'b0;
      chk("iflush_done", {63'h0, bus.Done}, 64'h0);
      chk("iflush_lo", {32'h0, bus.Lo}, 64'h2);

      // Reserved opcodes do nothing.
      nd = 0; nb = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         bus.Start = 1'b1; bus.Op = (k == 0) ? 3'b110 : 3'b111; bus.A = 32'hDEAD; bus.B = 32'h3;
         @(posedge Clk); #1;
         bus.Start = 1'b0;
         for (int c = 0; c < 4; c++) begin
            if (bus.Done) nd++;
            if (bus.Busy) nb++;
            @(posedge Clk); #1;
         end
      end
      chk("rsv_done", 64'(nd), 64'd0);
      chk("rsv_busy", 64'(nb), 64'd0);
      chk("rsv_hi", {32'h0, bus.Hi}, 64'h1);
      chk("rsv_lo", {32'h0, bus.Lo}, 64'h2);

      // Back-to-back MADD issued in the Done cycle of the previous one.
      run_op(OP_MTHI, 32'h0, 32'h0, lat, bc);
      run_op(OP_MTLO, 32'h0, 32'h0, lat, bc);
      run_op(OP_MADD, 32'h1, 32'h1, lat, bc);
      chk("b2b_first_lo", {32'h0, bus.Lo}, 64'h1);
      bus.Start = 1'b1; bus.Op = OP_MADD; bus.A = 32'h1; bus.B = 32'h1;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      chk("b2b_done_single", {63'h0, bus.Done}, 64'h0);
      chk("b2b_busy", {63'h0, bus.Busy}, 64'h1);
      lat = 0;
      while (bus.Done !== 1'b1 && lat < 60) begin @(posedge Clk); #1; lat++; end
      chk("b2b_lat", 64'(lat), 64'd33);
      chk("b2b_lo", {32'h0, bus.Lo}, 64'h2);
      chk("b2b_hi", {32'h0, bus.Hi}, 64'h0);

      // Asynchronous reset mid-MADD clears everything at once.
      run_op(OP_MTHI, 32'h5, 32'h0, lat, bc);
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = OP_MADD; bus.A = 32'd3; bus.B = 32'd3;
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      repeat (5) @(posedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      chk("arst_hi",   {32'h0, bus.Hi}, 64'h0);
      chk("arst_lo",   {32'h0, bus.Lo}, 64'h0);
      chk("arst_busy", {63'h0, bus.Busy}, 64'h0);
      chk("arst_done", {63'h0, bus.Done}, 64'h0);
      @(negedge Clk); Rst_n = 1'b1;
      run_op(OP_MULTU, 32'd2, 32'd3, lat, bc);
      chk("post_rst_lat", 64'(lat), 64'd33);
      chk("post_rst_lo", {32'h0, bus.Lo}, 64'h6);
      chk("post_rst_hi", {32'h0, bus.Hi}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hilo_mult_sequencer.md
# hilo_mult_sequencer

Multi-cycle HI/LO unit for the MIPS datapath: executes MULT, MULTU, MADD and MSUB with a 1-bit-per-cycle shift-add multiplier and owns the architectural HI and LO registers. MTHI and MTLO write HI and LO directly. The decode stage issues an operation with `Start`. The pipeline holds MFHI, MFLO and further HI/LO operations while `Busy` is high, then reads `Hi` and `Lo` directly.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits. A multiply takes `WIDTH` iteration cycles.

Ports:
- `Clk`  in  1  the only clock; everything is rising-edge.
- `Rst_n`  in  1  reset, asynchronous and active-low.
- `Start`  in  1  issues an operation; sampled only in IDLE.
- `Op`  in  3  operation code: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 11x reserved.
- `A`  in  WIDTH  rs operand.
- `B`  in  WIDTH  rt operand.
- `Flush`  in  1  synchronous abort of an in-flight multiply.
- `Busy`  out  1  multiply in progress; registered.
- `Done`  out  1  one-cycle pulse; registered.
- `Hi`  out  WIDTH  HI register.
- `Lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, ITER, FIX.
- IDLE, `Start`=1 with a multiply op (MULT, MULTU, MADD, MSUB):
  - latch `Op`;
  - latch |A| and |B|: magnitude for signed ops (MULT, MADD, MSUB), raw value for MULTU;
  - latch neg = A[WIDTH-1]^B[WIDTH-1] for signed ops, 0 for MULTU;
  - clear the 2*WIDTH product and the counter;
  - go to ITER.
- IDLE, `Start`=1 with MTHI or MTLO: write `A` to Hi or Lo, pulse `Done`, stay in IDLE.
- IDLE, `Start`=1 with a reserved op: ignored. No state change, no `Done`.
- ITER, each cycle:
  - if multiplier LSB is 1, add the shifted multiplicand into the product;
  - shift multiplicand left and multiplier right;
  - increment the counter;
  - after `WIDTH` iterations, go to FIX.
- FIX:
  - p = neg ? -product : product, 2*WIDTH bits;
  - MULT/MULTU: {Hi,Lo} = p;
  - MADD: {Hi,Lo} = {Hi,Lo} + p, modulo 2^(2*WIDTH);
  - MSUB: {Hi,Lo} = {Hi,Lo} - p, modulo 2^(2*WIDTH);
  - pulse `Done`, return to IDLE.
- Magnitude of the most negative value (0x80000000) is 2^31. It fits the unsigned `WIDTH`-bit path; no overflow special case.
- `Start` outside IDLE: ignored entirely. It is not queued.
- `Flush`:
  - in ITER or FIX: return to IDLE next edge; Hi/Lo unchanged; no `Done`;
  - in IDLE: any same-cycle `Start` is dropped (Flush wins).
- `Rst_n` low at any time, including mid-multiply: immediately IDLE; Hi=0, Lo=0, Busy=0, Done=0, counter and product cleared.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Hi`=0, `Lo`=0, state IDLE.
- Multiply, with edge E0 sampling `Start`:
  - `Busy`=1 after E0;
  - ITER occupies edges E1..E32 (for `WIDTH`=32);
  - FIX at E33 updates Hi/Lo, sets `Done`=1 and `Busy`=0;
  - total latency `WIDTH`+1 cycles; new Hi/Lo visible in the same cycle `Done` is high.
- Back-to-back: a new `Start` is accepted in the cycle `Done` is high (state is IDLE). Its `A`/`B` are sampled then; MADD uses the just-written Hi/Lo.
- MTHI/MTLO: `Hi`/`Lo` update at the sampling edge; `Done`=1 the following cycle; `Busy` stays 0.
- `Done` is never high for more than one consecutive cycle per operation.

## Structure
- Package `hilo_pkg`:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_MADD`, `OP_MSUB`, `OP_MTHI`, `OP_MTLO`;
  - state enum {IDLE, ITER, FIX};
  - default `WIDTH`.
- Sub-module `mul_iter_datapath`: product, multiplicand and multiplier registers, adder, shifter and counter. Controls in: `load`, `step`, `clear`. Status out: `last`, `product`.
- The top holds the FSM, operand sign handling, HI/LO registers and the accumulate adder.

## Test plan
- After reset: Hi=Lo=0, Busy=0. MULTU A=B=0xFFFFFFFF -> Busy high exactly 33 cycles; Done pulse with Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. MULT A=B=0x80000000 -> Hi=0x40000000, Lo=0.
- MTHI 0, MTLO 0x10, MADD 2*3 -> Hi=0, Lo=0x16. Then MSUB 5*5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD.
- MULTU 4*5 started, then `Start` with MTLO 0x99 at ITER cycle 3 -> ignored; final Lo=0x14; one Done pulse only.
- Flush in ITER cycle 10 of MULT 9*9 with Hi/Lo=0x1/0x2 -> Busy=0 next cycle, no Done, Hi/Lo stay 0x1/0x2. Rst_n low mid-MADD -> Hi=Lo=0 immediately.
- Op=110 with Start -> no Done, no Busy, Hi/Lo unchanged. Back-to-back MADD 1*1 issued in the Done cycle of the prior MADD 1*1 from 0 -> Lo=2.
